// File: rtl/dma_pkg.sv
// Shared types and constants for the NES sprite (OAM) DMA engine.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        GET   = 3'd3,
        PUT   = 3'd4
    } dma_state_e;

    localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA_REG = 16'h2004;
    localparam int          DMA_LEN      = 256;

endpackage

// File: rtl/oam_dma_master_sva.sv
// Bus-protocol invariants for oam_dma_master; bind or instantiate beside it.
module oam_dma_master_sva
    import dma_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_REG
) (
    input logic        clk,
    input logic        b_rst,
    input logic        cpu_rdy,
    input logic        dma_busy,
    input logic        dma_we,
    input logic [15:0] dma_addr
);

    a_put_addr: assert property (@(posedge clk) disable iff (!b_rst)
        dma_we |-> (dma_addr == OAM_DATA_ADDR));

    a_stall_busy: assert property (@(posedge clk) disable iff (!b_rst)
        (!cpu_rdy) == dma_busy);

endmodule

// File: rtl/oam_dma_master.sv
// OAM DMA bus initiator: snoops a CPU write to $4014, stalls the CPU and
// copies page $XX00..$XXFF to $2004 using alternating get/put cycles.
module oam_dma_master
    import dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_REG
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_we,
    output logic        dma_busy
);

    dma_state_e  state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        trigger;
    logic        last_byte;

    assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign last_byte = (idx_q == 8'(DMA_LEN - 1));

    always_ff @(posedge clk) begin
        if (!b_rst) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        data_d    = data_q;
        dma_addr  = 16'h0000;
        dma_wdata = 8'h00;
        dma_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            // An odd cycle here means the first get would land on a put slot.
            HALT:  state_d = parity_q ? ALIGN : GET;
            ALIGN: state_d = GET;
            GET: begin
                dma_addr = {page_q, idx_q};
                data_d   = mem_rdata;
                state_d  = PUT;
            end
            PUT: begin
                dma_addr  = OAM_DATA_ADDR;
                dma_wdata = data_q;
                dma_we    = 1'b1;
                if (last_byte) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = GET;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dma_busy   = (state_q != IDLE);
    assign dma_active = dma_busy;
    assign cpu_rdy    = ~dma_busy;

endmodule

// File: doc/oam_dma_master.md
# oam_dma_master

Bus initiator that performs the NES sprite (OAM) DMA on the CPU memory bus. It snoops CPU writes for a write to $4014, stalls the CPU, then copies 256 bytes from page $XX00 to the PPU OAM data port $2004 with get/put cycles. It sits between the CPU and the memory/PPU responder, beside the CPU as a second bus master, and drives the bus-ownership select.

## Interface
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA
- OAM_DATA_ADDR, 16'h2004, destination address of every put cycle
- clk  in  1  system clock, all logic on rising edge
- b_rst  in  1  synchronous, active-low reset
- cpu_addr  in  16  CPU bus address (snooped)
- cpu_wdata  in  8  CPU write data (snooped)
- cpu_we  in  1  CPU write strobe, 1 = write this cycle
- mem_rdata  in  8  read data from the memory responder, combinationally valid in the same cycle as dma_addr
- cpu_rdy  out  1  0 = CPU must hold its current cycle
- dma_active  out  1  1 = DMA owns the bus; the system mux selects the dma_* signals
- dma_addr  out  16  DMA bus address
- dma_wdata  out  8  DMA write data
- dma_we  out  1  DMA write strobe
- dma_busy  out  1  high from the trigger cycle + 1 through the last put

## Operation
- States: IDLE, HALT, ALIGN, GET, PUT.
- IDLE: trigger = cpu_we && cpu_addr == DMA_REG_ADDR.
  - On trigger, latch page <= cpu_wdata and idx <= 8'h00, then go to HALT.
  - Triggers seen in any other state are ignored.
- HALT: one cycle, bus idle (dma_active=1, dma_we=0, dma_addr=16'h0000).
  - parity==1 → ALIGN, else → GET.
- ALIGN: one idle cycle, same outputs as HALT, then → GET.
- GET: dma_addr={page, idx}, dma_we=0; latch data <= mem_rdata at the clock edge; → PUT.
- PUT: dma_addr=OAM_DATA_ADDR, dma_wdata=data, dma_we=1.
  - If idx==8'hFF → IDLE, else idx <= idx+1 (8-bit, no carry into page) → GET.
- parity: a 1-bit free-running register, toggled every cycle, 0 after reset. Sampled in HALT.
- cpu_rdy = 0 in every non-IDLE state; dma_active = dma_busy = (state != IDLE).
- Outputs in IDLE: dma_addr=16'h0000, dma_wdata=8'h00, dma_we=0.

## Timing
- Reset (b_rst=0 at an edge): next cycle state=IDLE, parity=0, idx=0, page=0, data=0.
  - Reset values of outputs: cpu_rdy=1, dma_active=0, dma_busy=0, dma_we=0, dma_addr=16'h0000, dma_wdata=8'h00.
  - Reset mid-transfer aborts with no further writes; OAM contents stay partial.
- Trigger write in cycle T: HALT in T+1, then optional ALIGN, first GET in T+2 or T+3.
- Transfer length:
  - Trigger at parity 0 (HALT sees parity 1, with ALIGN): 514 busy cycles.
  - Trigger at parity 1 (no ALIGN): 513 busy cycles.
- Exactly 256 cycles with dma_we=1, each one cycle after its GET.
- cpu_rdy returns to 1 in the cycle after the final PUT; the CPU resumes in that same cycle.
- A write to $4014 that coincides with reset deassertion is ignored; reset has priority.
- The trigger write itself completes normally; the CPU is not stalled in cycle T.

## Structure
- Package dma_pkg:
  - state enum dma_state_e {IDLE, HALT, ALIGN, GET, PUT}
  - constants OAM_DMA_REG=16'h4014, OAM_DATA_REG=16'h2004, DMA_LEN=256
- Single module, no sub-module required.
- The CPU/DMA bus multiplexer lives in the top level, selected by dma_active.
- A bind-able assertion file checks:
  - dma_we implies dma_addr==OAM_DATA_ADDR
  - !cpu_rdy == dma_busy

## Test plan
- Write $4014=8'h02 with parity 0 at trigger, memory $0200+i = i^8'hA5 → 514 busy cycles; 256 writes to $2004 with data 8'hA5, 8'hA4, … in order.
- Same trigger with parity 1 → no ALIGN, 513 busy cycles, first GET at T+2 with address 16'h0200.
- Page 8'hFF: reads $FF00..$FFFF, idx wraps, no read of $0000; returns to IDLE after the 256th put.
- Second write to $4014 during the transfer (forced on the snoop inputs) → ignored; page unchanged; exactly 256 puts.
- Reset asserted after 100 puts → next cycle all outputs at reset values; no further dma_we. A new trigger then runs a full 256-byte transfer.
- CPU write to $4015 or a CPU read of $4014 → no DMA; cpu_rdy stays 1.
